bl_cfg_tx: RTL and testbench
============================

# bl_cfg_tx

Bolometer-side serial configuration transmitter. Generates the master clock (BL_MC), sensor reset pulse (BL_RESET), serial configuration stream (BL_SERDATA) and integration-start pulse (BL_INT) that the balanced-line switch forwards to the sensor when TYPE=1. Sits between the host-side register block and the line switch. Monitors the sensor's BL_ERROR return line to abort a bad load.

## Interface
- MC_DIV, 4: system clocks per BL_MC half-period (≥2).
- CFG_W, 32: configuration word width in bits (≥8).
- RESET_MC, 8: BL_MC periods for which BL_RESET is held high (≥1).

- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  enables BL_MC generation; 0 holds BL_MC low and the divider cleared.
- START  in  1  one-cycle request; CFG_DATA is sampled on the same edge.
- CFG_DATA  in  CFG_W  configuration word, sent MSB first.
- BL_ERROR  in  1  sensor error return (synchronous to CLK).
- BUSY  out  1  high from the cycle after an accepted START until return to IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR_FLAG  out  1  sticky abort flag, cleared by next accepted START.
- BL_MC  out  1  sensor master clock.
- BL_RESET  out  1  sensor reset.
- BL_INT  out  1  integration-start pulse.
- BL_SERDATA  out  1  serial configuration data.

## Operation
- Reset values: every output 0; state IDLE; divider count 0; shift register 0.
- Divider: counter 0..MC_DIV-1 while EN; at MC_DIV-1 it wraps and BL_MC toggles. FALL strobe is 1 in the CLK cycle in which BL_MC goes 1->0. EN=0 clears counter, BL_MC=0, no strobes.
- States: IDLE, ARM, RSTP, SHIFT, INTP, FIN.
- IDLE: START=1 and EN=1 -> latch CFG_DATA, clear ERR_FLAG, go ARM. START while EN=0 or not IDLE is ignored (no latch, no flag change).
- ARM -> RSTP on next FALL; BL_RESET=1 from that edge.
- RSTP: stays RESET_MC FALL strobes; on the last, BL_RESET=0, BL_SERDATA=bit CFG_W-1, go SHIFT.
- SHIFT: each FALL presents the next bit (CFG_W-1 down to 0); the sensor samples on BL_MC rising. After bit 0 has been held one full MC period, the next FALL drives BL_SERDATA=0, BL_INT=1, go INTP.
- INTP: next FALL drives BL_INT=0, go FIN.
- FIN: one CLK cycle: DONE=1, BUSY=0 next, go IDLE.
- Abort: BL_ERROR=1 in any cycle of RSTP or SHIFT -> next edge: ERR_FLAG=1, BL_RESET=0, BL_SERDATA=0, state IDLE, no DONE. BL_ERROR ignored elsewhere.
- EN dropped while BUSY: FSM freezes (no FALL) with outputs held; resumes when EN returns.
- RST mid-operation: all state and outputs return to reset values immediately; no DONE, ERR_FLAG=0.

## Timing
- BL_MC period = 2*MC_DIV CLK cycles; first rising edge MC_DIV cycles after EN rises from reset.
- BL_RESET, BL_SERDATA, BL_INT change only in FALL cycles (plus abort/reset), registered, zero skew to BL_MC falling.
- Accepted START at edge t: BUSY=1 at t+1.
- Load duration from first FALL after ARM: (RESET_MC + CFG_W + 1) MC periods, then DONE 1 CLK cycle later.
- DONE and BUSY deassert together; START on the DONE cycle is ignored (FSM in FIN), accepted one cycle later.

## Structure
- Shared package bl_pkg: state enum (IDLE, ARM, RSTP, SHIFT, INTP, FIN), default constants for MC_DIV, CFG_W, RESET_MC.
- One sub-module: bl_mc_div (counter, BL_MC register, FALL strobe, EN handling). FSM, shift register and bit counter in bl_cfg_tx.

## Test plan
- MC_DIV=2, EN=1, no START -> BL_MC period 4 CLK, 50% duty, first rise 2 cycles after RST release; all other outputs 0.
- START with CFG_DATA=32'hA5C3_0F81, RESET_MC=8 -> BL_RESET high exactly 8 MC periods, then 32 bits A5C30F81 MSB first captured on BL_MC rising, BL_INT high one MC period, single DONE pulse; total 41 MC periods.
- BL_ERROR=1 during bit 10 of SHIFT -> ERR_FLAG=1 next cycle, BL_SERDATA/BL_RESET 0, BUSY 0, no DONE; next START clears ERR_FLAG and completes.
- Second START (CFG_DATA=32'hFFFF_FFFF) while BUSY -> ignored; first word transmitted unchanged, one DONE.
- RST asserted mid-SHIFT -> all outputs 0 same cycle, no DONE; new START after release completes normally.
- EN=0 for 20 CLK cycles mid-SHIFT -> BL_MC low, BL_SERDATA held, no bit skipped or repeated after EN=1.

Source files
------------

// File: rtl/bl_pkg.sv
// Shared types and default sizing for the bolometer serial configuration transmitter.
package bl_pkg;

  typedef enum logic [2:0] {IDLE, ARM, RSTP, SHIFT, INTP, FIN} bl_state_e;

  localparam int MC_DIV_DEF   = 4;
  localparam int CFG_W_DEF    = 32;
  localparam int RESET_MC_DEF = 8;

endpackage

// File: rtl/bl_mc_div.sv
// Sensor master-clock divider: toggles mc every MC_DIV enabled cycles and flags the
// cycle whose closing edge takes mc from 1 to 0.
module bl_mc_div
  import bl_pkg::*;
#(
  parameter int MC_DIV = MC_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mc,
  output logic fall
);

  localparam int CW = $clog2(MC_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(MC_DIV - 1));
  // Combinational so that registers updated on this strobe change with mc's falling edge.
  assign fall = en && wrap && mc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mc  <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mc  <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mc  <= ~mc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bl_cfg_tx.sv
// Bolometer configuration transmitter: reset pulse, MSB-first serial word and
// integration pulse, all retimed to falling edges of the generated master clock.
module bl_cfg_tx
  import bl_pkg::*;
#(
  parameter int MC_DIV   = MC_DIV_DEF,
  parameter int CFG_W    = CFG_W_DEF,
  parameter int RESET_MC = RESET_MC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [CFG_W-1:0] CFG_DATA,
  input  logic             BL_ERROR,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR_FLAG,
  output logic             BL_MC,
  output logic             BL_RESET,
  output logic             BL_INT,
  output logic             BL_SERDATA
);

  localparam int BW = $clog2(CFG_W);
  localparam int RW = $clog2(RESET_MC) + 1;

  bl_state_e        state;
  bl_state_e        nxt;
  logic             fall;
  logic [CFG_W-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [RW-1:0]    rst_cnt;
  logic             rst_last;

  bl_mc_div #(.MC_DIV(MC_DIV)) u_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (EN),
    .mc   (BL_MC),
    .fall (fall)
  );

  assign rst_last = (rst_cnt == RW'(RESET_MC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // With EN low there is no fall strobe, so every waiting state simply holds.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (START && EN) nxt = ARM;
      ARM:   if (fall) nxt = RSTP;
      RSTP:  if (BL_ERROR) nxt = IDLE;
             else if (fall && rst_last) nxt = SHIFT;
      SHIFT: if (BL_ERROR) nxt = IDLE;
             else if (fall && bit_cnt == '0) nxt = INTP;
      INTP:  if (fall) nxt = FIN;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
    DONE = (state == FIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      rst_cnt    <= '0;
      ERR_FLAG   <= 1'b0;
      BL_RESET   <= 1'b0;
      BL_INT     <= 1'b0;
      BL_SERDATA <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START && EN) begin
          shreg    <= CFG_DATA;
          ERR_FLAG <= 1'b0;
        end
        ARM: if (fall) begin
          BL_RESET <= 1'b1;
          rst_cnt  <= '0;
        end
        RSTP: if (BL_ERROR) begin
          ERR_FLAG   <= 1'b1;
          BL_RESET   <= 1'b0;
          BL_SERDATA <= 1'b0;
        end else if (fall) begin
          if (rst_last) begin
            BL_RESET   <= 1'b0;
            BL_SERDATA <= shreg[CFG_W-1];
            shreg      <= shreg << 1;
            bit_cnt    <= BW'(CFG_W - 1);
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        SHIFT: if (BL_ERROR) begin
          ERR_FLAG   <= 1'b1;
          BL_RESET   <= 1'b0;
          BL_SERDATA <= 1'b0;
        end else if (fall) begin
          // bit_cnt names the bit on the line; bit 0 has had its full period once it reads 0.
          if (bit_cnt == '0) begin
            BL_SERDATA <= 1'b0;
            BL_INT     <= 1'b1;
          end else begin
            BL_SERDATA <= shreg[CFG_W-1];
            shreg      <= shreg << 1;
            bit_cnt    <= bit_cnt - 1'b1;
          end
        end
        INTP: if (fall) BL_INT <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bl_cfg_tx.sv
// Directed bench for bl_cfg_tx with MC_DIV=2, CFG_W=32, RESET_MC=8.
module tb_bl_cfg_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        START = 1'b0;
  logic [31:0] CFG_DATA = '0;
  logic        BL_ERROR = 1'b0;
  logic        BUSY, DONE, ERR_FLAG, BL_MC, BL_RESET, BL_INT, BL_SERDATA;

  int compared = 0;
  int mismatched = 0;

  bl_cfg_tx #(.MC_DIV(2), .CFG_W(32), .RESET_MC(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .START      (START),
    .CFG_DATA   (CFG_DATA),
    .BL_ERROR   (BL_ERROR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR_FLAG   (ERR_FLAG),
    .BL_MC      (BL_MC),
    .BL_RESET   (BL_RESET),
    .BL_INT     (BL_INT),
    .BL_SERDATA (BL_SERDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] cfg;
    int          err_at;
    int          jam_at;
    int          gap_at;
    logic [31:0] exp_word;
    int          exp_bits;
    int          exp_rst;
    int          exp_int;
    int          exp_done;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] word = '0;
    int nbits = 0, nrst = 0, nint = 0, ndone = 0;
    int t_rst = -1, t_done = -1, cyc, gap_left = 0, gap_bad = 0;
    logic prev_mc, hold = 1'b0, seen_rst = 1'b0;
    logic err_pend = 1'b0, errd = 1'b0, jam_pend = 1'b0, jammed = 1'b0, gapped = 1'b0;
    logic rise, fall, finished = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    CFG_DATA = v.cfg;
    prev_mc = BL_MC;
    for (cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        START = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), {31'b0, BUSY}, 32'd1);
        chk($sformatf("v%0d_err_cleared", idx), {31'b0, ERR_FLAG}, 32'd0);
      end
      if (jam_pend) begin
        START = 1'b0;
        jam_pend = 1'b0;
      end
      if (err_pend) begin
        BL_ERROR = 1'b0;
        err_pend = 1'b0;
        chk($sformatf("v%0d_abort_outputs", idx),
            {27'b0, ERR_FLAG, BUSY, BL_SERDATA, BL_RESET, DONE}, 32'b10000);
      end
      rise = BL_MC && !prev_mc;
      fall = !BL_MC && prev_mc;
      prev_mc = BL_MC;
      if (BL_RESET && !seen_rst) begin
        seen_rst = 1'b1;
        t_rst = cyc;
      end
      if (rise) begin
        if (BL_RESET) nrst++;
        else if (BL_INT) nint++;
        else if (seen_rst && nint == 0) begin
          word = {word[30:0], BL_SERDATA};
          nbits++;
        end
      end
      if (gap_left > 0) begin
        if (BL_MC !== 1'b0 || BL_SERDATA !== hold) gap_bad++;
        gap_left--;
        if (gap_left == 0) EN = 1'b1;
      end
      if (rise && v.err_at == nbits && !errd) begin
        BL_ERROR = 1'b1;
        err_pend = 1'b1;
        errd = 1'b1;
      end
      if (rise && v.jam_at == nbits && !jammed) begin
        START = 1'b1;
        CFG_DATA = 32'hFFFF_FFFF;
        jam_pend = 1'b1;
        jammed = 1'b1;
      end
      if (fall && v.gap_at == nbits && !gapped) begin
        EN = 1'b0;
        hold = BL_SERDATA;
        gap_left = 20;
        gapped = 1'b1;
      end
      if (DONE) begin
        ndone++;
        t_done = cyc;
      end
      if (!BUSY && !err_pend) begin
        finished = 1'b1;
        break;
      end
    end
    EN = 1'b1;
    START = 1'b0;
    BL_ERROR = 1'b0;
    if (!finished) begin
      compared++;
      mismatched++;
      $display("FAIL v%0d_timeout: got busy after 1000 cycles expected idle", idx);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk($sformatf("v%0d_word", idx), word, v.exp_word);
    chk($sformatf("v%0d_bits", idx), nbits, v.exp_bits);
    chk($sformatf("v%0d_reset_periods", idx), nrst, v.exp_rst);
    chk($sformatf("v%0d_int_periods", idx), nint, v.exp_int);
    chk($sformatf("v%0d_done_pulses", idx), ndone, v.exp_done);
    chk($sformatf("v%0d_err_flag", idx), {31'b0, ERR_FLAG}, {31'b0, v.exp_err});
    if (v.exp_done > 0)
      chk($sformatf("v%0d_load_cycles", idx), t_done - t_rst, v.exp_cycles);
    if (v.gap_at >= 0)
      chk($sformatf("v%0d_gap_hold", idx), gap_bad, 0);
  endtask

  initial begin
    logic [11:0] mc_pat;
    int waited;
    // cfg, err_at, jam_at, gap_at, exp_word, bits, rst, int, done, err, cycles
    vecs[0] = '{32'hA5C3_0F81, -1, -1, -1, 32'hA5C3_0F81, 32, 8, 1, 1, 1'b0, 164};
    vecs[1] = '{32'h0000_0000, -1, -1, -1, 32'h0000_0000, 32, 8, 1, 1, 1'b0, 164};
    vecs[2] = '{32'h8000_0001, -1, -1, -1, 32'h8000_0001, 32, 8, 1, 1, 1'b0, 164};
    vecs[3] = '{32'hA5C3_0F81, 22, -1, -1, 32'h0029_70C3, 22, 8, 0, 0, 1'b1, 0};
    vecs[4] = '{32'hA5C3_0F81, -1, -1, -1, 32'hA5C3_0F81, 32, 8, 1, 1, 1'b0, 164};
    vecs[5] = '{32'h5A5A_1234, -1, 5, -1, 32'h5A5A_1234, 32, 8, 1, 1, 1'b0, 164};
    vecs[6] = '{32'hC0FF_EE11, -1, -1, 12, 32'hC0FF_EE11, 32, 8, 1, 1, 1'b0, 184};

    // Reset state and divider waveform.
    #1;
    chk("reset_outputs", {25'b0, BUSY, DONE, ERR_FLAG, BL_MC, BL_RESET, BL_INT, BL_SERDATA}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mc_pat = 12'b0110_0110_0110;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk($sformatf("mc_wave_%0d", i), {31'b0, BL_MC}, {31'b0, mc_pat[11-i]});
      chk($sformatf("idle_outputs_%0d", i),
          {26'b0, BUSY, DONE, ERR_FLAG, BL_RESET, BL_INT, BL_SERDATA}, 32'd0);
    end

    // START with EN low is ignored.
    EN = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    CFG_DATA = 32'h1234_5678;
    @(negedge CLK);
    START = 1'b0;
    chk("start_en0_ignored", {30'b0, BUSY, BL_MC}, 32'd0);
    EN = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // START landing on the DONE cycle is ignored; the following cycle is accepted.
    @(negedge CLK);
    START = 1'b1;
    CFG_DATA = 32'h0F0F_0F0F;
    @(negedge CLK);
    START = 1'b0;
    waited = 0;
    while (!DONE && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("done_reached", {31'b0, DONE}, 32'd1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("start_on_done_ignored", {31'b0, BUSY}, 32'd0);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("start_after_done_accepted", {31'b0, BUSY}, 32'd1);
    waited = 0;
    while (BUSY && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("second_load_finished", {31'b0, BUSY}, 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge CLK);
    START = 1'b1;
    CFG_DATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    START = 1'b0;
    repeat (60) @(negedge CLK);
    chk("mid_shift_busy", {31'b0, BUSY}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid_outputs", {25'b0, BUSY, DONE, ERR_FLAG, BL_MC, BL_RESET, BL_INT, BL_SERDATA}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) waited++;
    end
    chk("rst_no_done", waited, 0);
    run_vec(vecs[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
